// File: rtl/ibex_fpu_poly_seq_pkg.sv
// Shared types and constants for the FPU polynomial (Horner) sequencer.
package ibex_fpu_poly_seq_pkg;

    typedef enum logic [1:0] {
        FPU_SEQ_IDLE,
        FPU_SEQ_MUL,
        FPU_SEQ_ADD,
        FPU_SEQ_DONE
    } fpu_seq_state_e;

    typedef enum logic [1:0] {
        FPU_OP_ADD = 2'd0,
        FPU_OP_MUL = 2'd1
    } fpu_op_e;

    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

endpackage

// File: rtl/ibex_fpu_poly_seq_coef_rf.sv
// Coefficient table: flop array with one write port and two asynchronous read ports,
// cleared by the synchronous active-low reset.
module ibex_fpu_coef_rf #(
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [AddrWidth-1:0] raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o
);

    logic [Depth-1:0][DataWidth-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/ibex_fpu_poly_seq.sv
// Horner-evaluation sequencer that drives an external FPU with alternating MUL/ADD ops.
// Define IBEX_FPU_SEQ_EARLY_EXIT_EN to abort an evaluation on the first invalid FPU result.
module ibex_fpu_poly_seq
    import ibex_fpu_poly_seq_pkg::*;
#(
    parameter int unsigned MaxDegree = 7,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned AW = $clog2(MaxDegree + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 coef_we_i,
    input  logic [AW-1:0]        coef_addr_i,
    input  logic [DataWidth-1:0] coef_wdata_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_x_i,
    input  logic [AW-1:0]        req_degree_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_result_o,
    output logic [2:0]           rsp_flags_o,
    output logic                 fpu_en_o,
    output fpu_op_e              fpu_operator_o,
    output logic [DataWidth-1:0] fpu_operand_a_o,
    output logic [DataWidth-1:0] fpu_operand_b_o,
    input  logic [DataWidth-1:0] fpu_result_i,
    input  logic                 fpu_valid_i,
    input  logic                 fpu_overflow_i,
    input  logic                 fpu_underflow_i,
    input  logic                 fpu_invalid_i
);

    localparam logic [AW:0] MaxDegExt = (AW + 1)'(MaxDegree);

    fpu_seq_state_e       state_q, state_d;
    logic [DataWidth-1:0] acc_q, acc_d, x_q, x_d;
    logic [AW-1:0]        k_q, k_d;
    logic [2:0]           flags_q, flags_d;
    logic                 fpu_en_q, fpu_en_d;
    fpu_op_e              fpu_op_q, fpu_op_d;
    logic [DataWidth-1:0] opa_q, opa_d, opb_q, opb_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]           rsp_flags_q, rsp_flags_d;

    logic                 req_fire, coef_we, early_exit;
    logic [2:0]           fpu_flags;
    logic [DataWidth-1:0] coef_deg, coef_k;

    assign req_ready_o = (state_q == FPU_SEQ_IDLE) && !coef_we_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign coef_we     = coef_we_i && (state_q == FPU_SEQ_IDLE || state_q == FPU_SEQ_DONE);
    assign fpu_flags   = {fpu_invalid_i, fpu_overflow_i, fpu_underflow_i};

`ifdef IBEX_FPU_SEQ_EARLY_EXIT_EN
    assign early_exit = fpu_invalid_i;
`else
    assign early_exit = 1'b0;
`endif

    // Port B is addressed with the next k so the ADD operand is ready as that state is entered.
    ibex_fpu_coef_rf #(
        .Depth    (MaxDegree + 1),
        .DataWidth(DataWidth),
        .AddrWidth(AW)
    ) u_coef_rf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (coef_we),
        .waddr_i  (coef_addr_i),
        .wdata_i  (coef_wdata_i),
        .raddr_a_i(req_degree_i),
        .rdata_a_o(coef_deg),
        .raddr_b_i(k_d),
        .rdata_b_o(coef_k)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        k_d     = k_q;
        flags_d = flags_q;
        case (state_q)
            FPU_SEQ_IDLE: begin
                if (req_fire) begin
                    x_d     = req_x_i;
                    acc_d   = coef_deg;
                    k_d     = req_degree_i - AW'(1);
                    flags_d = '0;
                    if ({1'b0, req_degree_i} > MaxDegExt) begin
                        acc_d   = FPU_QNAN;
                        flags_d = 3'b100;
                        state_d = FPU_SEQ_DONE;
                    end else if (req_degree_i == '0) begin
                        state_d = FPU_SEQ_DONE;
                    end else begin
                        state_d = FPU_SEQ_MUL;
                    end
                end
            end
            FPU_SEQ_MUL, FPU_SEQ_ADD: begin
                if (fpu_valid_i) begin
                    acc_d   = fpu_result_i;
                    flags_d = flags_q | fpu_flags;
                    if (early_exit) begin
                        acc_d   = FPU_QNAN;
                        state_d = FPU_SEQ_DONE;
                    end else if (state_q == FPU_SEQ_MUL) begin
                        state_d = FPU_SEQ_ADD;
                    end else if (k_q == '0) begin
                        state_d = FPU_SEQ_DONE;
                    end else begin
                        k_d     = k_q - AW'(1);
                        state_d = FPU_SEQ_MUL;
                    end
                end
            end
            FPU_SEQ_DONE: begin
                if (rsp_ready_i) begin
                    state_d = FPU_SEQ_IDLE;
                end
            end
            default: state_d = FPU_SEQ_IDLE;
        endcase
    end

    // Outputs are derived from the next state so they appear registered with no extra cycle.
    always_comb begin
        fpu_en_d     = (state_d == FPU_SEQ_MUL) || (state_d == FPU_SEQ_ADD);
        fpu_op_d     = (state_d == FPU_SEQ_MUL) ? FPU_OP_MUL : FPU_OP_ADD;
        opa_d        = fpu_en_d ? acc_d : '0;
        opb_d        = '0;
        if (state_d == FPU_SEQ_MUL) begin
            opb_d = x_d;
        end else if (state_d == FPU_SEQ_ADD) begin
            opb_d = coef_k;
        end
        rsp_valid_d  = (state_d == FPU_SEQ_DONE);
        rsp_result_d = rsp_valid_d ? acc_d : '0;
        rsp_flags_d  = rsp_valid_d ? flags_d : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= FPU_SEQ_IDLE;
            acc_q        <= '0;
            x_q          <= '0;
            k_q          <= '0;
            flags_q      <= '0;
            fpu_en_q     <= 1'b0;
            fpu_op_q     <= FPU_OP_ADD;
            opa_q        <= '0;
            opb_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            k_q          <= k_d;
            flags_q      <= flags_d;
            fpu_en_q     <= fpu_en_d;
            fpu_op_q     <= fpu_op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign fpu_en_o        = fpu_en_q;
    assign fpu_operator_o  = fpu_op_q;
    assign fpu_operand_a_o = opa_q;
    assign fpu_operand_b_o = opb_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_result_o    = rsp_result_q;
    assign rsp_flags_o     = rsp_flags_q;

endmodule

// File: tb/tb_ibex_fpu_poly_seq.sv
// Bench for ibex_fpu_poly_seq: FPU stub plus a Horner reference model checked every cycle,
// and directed evaluations with hand-computed results.
module tb_ibex_fpu_poly_seq;
    import ibex_fpu_poly_seq_pkg::*;

    localparam int MaxDegree = 7;
`ifdef IBEX_FPU_SEQ_EARLY_EXIT_EN
    localparam int NanLat = 2;
`else
    localparam int NanLat = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        coef_we_i = 1'b0;
    logic [2:0]  coef_addr_i = '0;
    logic [31:0] coef_wdata_i = '0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_x_i = '0;
    logic [2:0]  req_degree_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_result_o;
    logic [2:0]  rsp_flags_o;
    logic        fpu_en_o;
    fpu_op_e     fpu_operator_o;
    logic [31:0] fpu_operand_a_o, fpu_operand_b_o, fpu_result_i;
    logic        fpu_valid_i, fpu_overflow_i, fpu_underflow_i, fpu_invalid_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fpu_lat = 0;
    int lat_cnt = 0;

    ibex_fpu_poly_seq dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .coef_we_i      (coef_we_i),
        .coef_addr_i    (coef_addr_i),
        .coef_wdata_i   (coef_wdata_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_x_i        (req_x_i),
        .req_degree_i   (req_degree_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_result_o   (rsp_result_o),
        .rsp_flags_o    (rsp_flags_o),
        .fpu_en_o       (fpu_en_o),
        .fpu_operator_o (fpu_operator_o),
        .fpu_operand_a_o(fpu_operand_a_o),
        .fpu_operand_b_o(fpu_operand_b_o),
        .fpu_result_i   (fpu_result_i),
        .fpu_valid_i    (fpu_valid_i),
        .fpu_overflow_i (fpu_overflow_i),
        .fpu_underflow_i(fpu_underflow_i),
        .fpu_invalid_i  (fpu_invalid_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-precision <-> real conversions (normals only; tiny results flush to zero)
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'h00) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'b0});
    endfunction

    function automatic logic [34:0] r2f(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {3'b000, d[63], 31'b0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {3'b010, d[63], 8'hFF, 23'b0};
        if (e <= 0) return {3'b001, d[63], 31'b0};
        return {3'b000, d[63], e[7:0], d[51:29]};
    endfunction

    // returns {invalid, overflow, underflow, result}
    function automatic logic [34:0] fpu_calc(input fpu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic anan, bnan, ainf, binf, azero, bzero;
        anan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bnan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ainf  = (a[30:0] == 31'h7F800000);
        binf  = (b[30:0] == 31'h7F800000);
        azero = (a[30:0] == 31'd0);
        bzero = (b[30:0] == 31'd0);
        if (anan || bnan) return {3'b100, FPU_QNAN};
        if (op == FPU_OP_MUL) begin
            if ((ainf && bzero) || (binf && azero)) return {3'b100, FPU_QNAN};
            if (ainf || binf) return {3'b000, a[31] ^ b[31], 31'h7F800000};
            return r2f(f2r(a) * f2r(b));
        end
        if (ainf && binf && (a[31] != b[31])) return {3'b100, FPU_QNAN};
        if (ainf) return {3'b000, a};
        if (binf) return {3'b000, b};
        return r2f(f2r(a) + f2r(b));
    endfunction

    // FPU stub: result valid fpu_lat cycles after the operation is presented
    logic [34:0] stub;
    always_comb stub = fpu_calc(fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o);
    always @(posedge clk) lat_cnt <= (fpu_en_o && !fpu_valid_i) ? lat_cnt + 1 : 0;
    assign fpu_valid_i     = fpu_en_o && (lat_cnt == fpu_lat);
    assign fpu_result_i    = stub[31:0];
    assign fpu_invalid_i   = stub[34] && fpu_valid_i;
    assign fpu_overflow_i  = stub[33] && fpu_valid_i;
    assign fpu_underflow_i = stub[32] && fpu_valid_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: table contents plus one outstanding evaluation, checked at each negedge
    logic [31:0] coef_m [MaxDegree+1];
    logic        armed = 1'b0;
    logic        pending = 1'b0;
    logic        done;
    int          exp_cyc = 0;
    logic [31:0] exp_res = '0;
    logic [2:0]  exp_flg = '0;

    initial begin
        logic [31:0] acc;
        logic [2:0]  flg;
        logic [34:0] r;
        int          steps;
        bit          stop;
        forever begin
            @(negedge clk);
            done = pending && (cyc >= exp_cyc);
            if (armed) begin
                checkOutput("cmp_rsp_valid", 32'(rsp_valid_o), 32'(done));
                checkOutput("cmp_req_ready", 32'(req_ready_o), 32'(!pending && !coef_we_i));
                if (done) begin
                    checkOutput("cmp_rsp_result", rsp_result_o, exp_res);
                    checkOutput("cmp_rsp_flags", 32'(rsp_flags_o), 32'(exp_flg));
                end
                if (!pending || done) begin
                    checkOutput("cmp_fpu_en_idle", 32'(fpu_en_o), 32'd0);
                    checkOutput("cmp_opa_idle", fpu_operand_a_o, 32'd0);
                    checkOutput("cmp_opb_idle", fpu_operand_b_o, 32'd0);
                end
            end
            if (!rst_ni) begin
                armed   = 1'b1;
                pending = 1'b0;
                for (int i = 0; i <= MaxDegree; i++) coef_m[i] = '0;
            end else if (armed) begin
                if (coef_we_i && (!pending || done)) coef_m[coef_addr_i] = coef_wdata_i;
                if (req_valid_i && !pending && !coef_we_i) begin
                    acc   = coef_m[req_degree_i];
                    flg   = '0;
                    steps = 0;
                    stop  = 1'b0;
                    for (int k = int'(req_degree_i) - 1; k >= 0 && !stop; k--) begin
                        r = fpu_calc(FPU_OP_MUL, acc, req_x_i);
                        acc = r[31:0];
                        flg |= r[34:32];
                        steps++;
`ifdef IBEX_FPU_SEQ_EARLY_EXIT_EN
                        if (r[34]) begin acc = FPU_QNAN; stop = 1'b1; end
`endif
                        if (!stop) begin
                            r = fpu_calc(FPU_OP_ADD, acc, coef_m[k]);
                            acc = r[31:0];
                            flg |= r[34:32];
                            steps++;
`ifdef IBEX_FPU_SEQ_EARLY_EXIT_EN
                            if (r[34]) begin acc = FPU_QNAN; stop = 1'b1; end
`endif
                        end
                    end
                    exp_res = acc;
                    exp_flg = flg;
                    exp_cyc = cyc + steps * (fpu_lat + 1) + 1;
                    pending = 1'b1;
                end else if (done && rsp_ready_i) begin
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit we, input logic [2:0] addr, input logic [31:0] data,
                                 input bit rv, input logic [31:0] x, input logic [2:0] deg);
        coef_we_i    = we;
        coef_addr_i  = addr;
        coef_wdata_i = data;
        req_valid_i  = rv;
        req_x_i      = x;
        req_degree_i = deg;
    endtask

    task automatic writeCoef(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 32'd0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0);
    endtask

    task automatic runEval(input string name, input logic [31:0] x, input logic [2:0] deg,
                           input logic [31:0] expRes, input logic [2:0] expFlg, input int expLat,
                           input bit hold, input bit wrMid);
        int n;
        bit enSeen;
        rsp_ready_i = !hold;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, x, deg);
        #1;
        checkOutput({name, "_req_ready"}, 32'(req_ready_o), 32'd1);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, x, deg);
        n = 1;
        enSeen = 1'b0;
        while (!rsp_valid_o && n < 200) begin
            if (fpu_en_o) enSeen = 1'b1;
            if (wrMid && n == 2) applyStimulus(1'b1, 3'd0, 32'h12345678, 1'b0, x, deg);
            else applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, x, deg);
            tick();
            n++;
        end
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0);
        if (!rsp_valid_o) begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
            checkOutput({name, "_result"}, rsp_result_o, expRes);
            checkOutput({name, "_flags"}, 32'(rsp_flags_o), 32'(expFlg));
            if (deg == 3'd0) checkOutput({name, "_no_fpu"}, 32'(enSeen), 32'd0);
            if (hold) begin
                repeat (5) begin
                    tick();
                    checkOutput({name, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
                    checkOutput({name, "_hold_result"}, rsp_result_o, expRes);
                    checkOutput({name, "_hold_flags"}, 32'(rsp_flags_o), 32'(expFlg));
                    checkOutput({name, "_hold_req_ready"}, 32'(req_ready_o), 32'd0);
                end
                rsp_ready_i = 1'b1;
            end
            tick();
            checkOutput({name, "_released"}, 32'(rsp_valid_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        rst_ni = 1'b1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_fpu_en", 32'(fpu_en_o), 32'd0);
        checkOutput("reset_fpu_op", 32'(fpu_operator_o), 32'(FPU_OP_ADD));
        checkOutput("reset_rsp_result", rsp_result_o, 32'd0);
        checkOutput("reset_rsp_flags", 32'(rsp_flags_o), 32'd0);

        writeCoef(3'd0, 32'h3F800000);
        writeCoef(3'd1, 32'h40000000);
        runEval("deg1", 32'h40400000, 3'd1, 32'h40E00000, 3'b000, 3, 1'b0, 1'b0);

        writeCoef(3'd2, 32'h3F800000);
        runEval("deg2", 32'h40000000, 3'd2, 32'h41100000, 3'b000, 5, 1'b0, 1'b0);

        runEval("deg0", 32'h40400000, 3'd0, 32'h3F800000, 3'b000, 1, 1'b0, 1'b0);

        writeCoef(3'd0, 32'h00000000);
        runEval("ovf", 32'h7F000000, 3'd1, 32'h7F800000, 3'b010, 3, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) writeCoef(3'(i), 32'h3F800000);
        runEval("nan", 32'h7FC00000, 3'd3, 32'h7FC00000, 3'b100, NanLat, 1'b0, 1'b0);

        fpu_lat = 2;
        runEval("slow_fpu", 32'h40000000, 3'd2, 32'h40E00000, 3'b000, 13, 1'b0, 1'b1);
        fpu_lat = 0;
        runEval("drop_wr", 32'h00000000, 3'd0, 32'h3F800000, 3'b000, 1, 1'b0, 1'b0);

        runEval("hold", 32'h40400000, 3'd1, 32'h40800000, 3'b000, 3, 1'b1, 1'b0);

        applyStimulus(1'b1, 3'd0, 32'h40A00000, 1'b1, 32'd0, 3'd0);
        #1;
        checkOutput("wr_beats_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0);
        checkOutput("wr_beats_req_no_rsp", 32'(rsp_valid_o), 32'd0);
        runEval("wr_landed", 32'd0, 3'd0, 32'h40A00000, 3'b000, 1, 1'b0, 1'b0);

        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 32'h40000000, 3'd2);
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 3'd0);
        tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (4) begin
            checkOutput("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            checkOutput("midrst_fpu_en", 32'(fpu_en_o), 32'd0);
            tick();
        end
        runEval("table_cleared", 32'd0, 3'd0, 32'h00000000, 3'b000, 1, 1'b0, 1'b0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
